// File: rtl/spi_slave_pkg.sv
// Shared constants and state type for the SPI register-file slave.
package spi_slave_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  localparam int CMD_BITS  = 8;
  localparam int ADDR_BITS = 8;
  localparam int DATA_BITS = 32;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RDATA,
    IGNORE
  } spi_slv_state_e;

endpackage

// File: rtl/spi_slave_regif_if.sv
// SPI pin bundle between a single-lane master and the register-file slave.
// Handshake: none; spi_clk/spi_csn/spi_sdi are asynchronous pins oversampled by the slave.
interface spi_slave_regif_if;
  logic spi_clk;
  logic spi_csn;
  logic spi_sdi;
  logic spi_sdo;
  logic spi_sdo_oe;

  modport master (output spi_clk, output spi_csn, output spi_sdi,
                  input  spi_sdo, input  spi_sdo_oe);
  modport slave  (input  spi_clk, input  spi_csn, input  spi_sdi,
                  output spi_sdo, output spi_sdo_oe);
endinterface

// File: rtl/spi_slave_regif_sync_edge.sv
// Synchronises the SPI pins into clk and produces one-cycle rise/fall strobes.
module spi_slave_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sclk,
  input  logic i_csn,
  input  logic i_sdi,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_csn_rise,
  output logic o_csn_fall,
  output logic o_sdi
);

  // Chains reset low so a csn held low across reset never looks like a fresh fall.
  logic [SYNC_STAGES:0]   r_sclk_sync;
  logic [SYNC_STAGES:0]   r_csn_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_csn_sync  <= '0;
      r_sdi_sync  <= '0;
    end else begin
      r_sclk_sync[0] <= i_sclk;
      r_csn_sync[0]  <= i_csn;
      r_sdi_sync[0]  <= i_sdi;
      for (int i = 1; i <= SYNC_STAGES; i++) begin
        r_sclk_sync[i] <= r_sclk_sync[i-1];
        r_csn_sync[i]  <= r_csn_sync[i-1];
      end
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sdi_sync[i] <= r_sdi_sync[i-1];
      end
    end
  end

  // Data tap sits at the same depth as the edge-compare tap, so a rise strobe sees the bit it clocks.
  assign o_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_sync[SYNC_STAGES];
  assign o_sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_sync[SYNC_STAGES];
  assign o_csn_rise  = r_csn_sync[SYNC_STAGES-1] & ~r_csn_sync[SYNC_STAGES];
  assign o_csn_fall  = ~r_csn_sync[SYNC_STAGES-1] & r_csn_sync[SYNC_STAGES];
  assign o_sdi       = r_sdi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_regif.sv
// Mode-0 SPI slave: CMD byte, ADDR byte, then 32-bit words to/from a word-addressed register file.
module spi_slave_regif
  import spi_slave_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  spi_slave_regif_if.slave spi,
  input  logic [AW-1:0]   loc_addr,
  output logic [31:0]     loc_rdata,
  output logic            wr_pulse,
  output logic [AW-1:0]   wr_addr,
  output logic            err_cmd,
  output spi_slv_state_e  o_dbg_state
);

  spi_slv_state_e r_state, w_next;

  logic [4:0]    r_bit_cnt;
  logic [31:0]   r_shift_in, r_shift_out, w_shift_next;
  logic [AW-1:0] r_addr, w_addr_inc, r_wr_addr;
  logic          r_is_read, r_sdo, r_wr_pulse, r_err_cmd;
  logic [31:0]   r_regs [DEPTH];

  logic w_sclk_rise, w_sclk_fall, w_csn_rise, w_csn_fall, w_sdi;
  logic w_bit_en, w_cmd_done, w_addr_done, w_word_done, w_cmd_ok;

  spi_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk         (clk),
    .reset       (reset),
    .i_sclk      (spi.spi_clk),
    .i_csn       (spi.spi_csn),
    .i_sdi       (spi.spi_sdi),
    .o_sclk_rise (w_sclk_rise),
    .o_sclk_fall (w_sclk_fall),
    .o_csn_rise  (w_csn_rise),
    .o_csn_fall  (w_csn_fall),
    .o_sdi       (w_sdi)
  );

  always_comb begin
    // A csn rise in the same cycle as a clock rise discards that bit.
    w_bit_en     = w_sclk_rise & ~w_csn_rise;
    w_shift_next = {r_shift_in[30:0], w_sdi};
    w_cmd_done   = w_bit_en && (r_bit_cnt == 5'(CMD_BITS - 1));
    w_addr_done  = w_bit_en && (r_bit_cnt == 5'(ADDR_BITS - 1));
    w_word_done  = w_bit_en && (r_bit_cnt == 5'(DATA_BITS - 1));
    w_cmd_ok     = (w_shift_next[7:0] == CMD_WRITE) || (w_shift_next[7:0] == CMD_READ);
    w_addr_inc   = r_addr + AW'(1);

    w_next = r_state;
    case (r_state)
      IDLE:    if (w_csn_fall)  w_next = CMD;
      CMD:     if (w_cmd_done)  w_next = w_cmd_ok ? ADDR : IGNORE;
      ADDR:    if (w_addr_done) w_next = r_is_read ? RDATA : WDATA;
      default: w_next = r_state;
    endcase
    if (w_csn_rise) w_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_shift_in  <= '0;
      r_shift_out <= '0;
      r_addr      <= '0;
      r_is_read   <= 1'b0;
      r_sdo       <= 1'b0;
      r_wr_pulse  <= 1'b0;
      r_wr_addr   <= '0;
      r_err_cmd   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      r_state    <= w_next;
      r_wr_pulse <= 1'b0;
      if (w_csn_rise) begin
        r_bit_cnt <= '0;
      end else begin
        case (r_state)
          IDLE: r_bit_cnt <= '0;
          CMD: if (w_bit_en) begin
            r_shift_in <= w_shift_next;
            r_bit_cnt  <= w_cmd_done ? 5'd0 : r_bit_cnt + 5'd1;
            if (w_cmd_done) begin
              r_is_read <= (w_shift_next[7:0] == CMD_READ);
              if (!w_cmd_ok) r_err_cmd <= 1'b1;
            end
          end
          ADDR: if (w_bit_en) begin
            r_shift_in <= w_shift_next;
            r_bit_cnt  <= w_addr_done ? 5'd0 : r_bit_cnt + 5'd1;
            if (w_addr_done) begin
              r_addr <= w_shift_next[AW-1:0];
              if (r_is_read) r_shift_out <= r_regs[w_shift_next[AW-1:0]];
            end
          end
          WDATA: if (w_bit_en) begin
            r_shift_in <= w_shift_next;
            r_bit_cnt  <= w_word_done ? 5'd0 : r_bit_cnt + 5'd1;
            if (w_word_done) begin
              r_regs[r_addr] <= w_shift_next;
              r_wr_pulse     <= 1'b1;
              r_wr_addr      <= r_addr;
              r_addr         <= w_addr_inc;
            end
          end
          RDATA: begin
            if (w_sclk_fall) {r_sdo, r_shift_out} <= {r_shift_out, 1'b0};
            if (w_bit_en) begin
              r_bit_cnt <= w_word_done ? 5'd0 : r_bit_cnt + 5'd1;
              if (w_word_done) begin
                r_addr      <= w_addr_inc;
                r_shift_out <= r_regs[w_addr_inc];
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign spi.spi_sdo    = r_sdo;
  assign spi.spi_sdo_oe = (r_state == RDATA);
  assign loc_rdata      = r_regs[loc_addr];
  assign wr_pulse       = r_wr_pulse;
  assign wr_addr        = r_wr_addr;
  assign err_cmd        = r_err_cmd;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_spi_slave_regif.sv
// Randomised SPI-master stimulus against a register-array model of the slave.
module tb_spi_slave_regif;
  import spi_slave_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int HALF  = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [AW-1:0]  loc_addr = '0;
  logic [31:0]    loc_rdata;
  logic           wr_pulse;
  logic [AW-1:0]  wr_addr;
  logic           err_cmd;
  spi_slv_state_e dbg_state;

  spi_slave_regif_if spi_bus ();

  spi_slave_regif #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .spi         (spi_bus),
    .loc_addr    (loc_addr),
    .loc_rdata   (loc_rdata),
    .wr_pulse    (wr_pulse),
    .wr_addr     (wr_addr),
    .err_cmd     (err_cmd),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- model state ----------------
  logic [31:0]   model_regs [DEPTH];
  logic          model_err;
  logic [AW-1:0] exp_q[$];
  logic [31:0]   exp_old_q[$];
  logic [31:0]   exp_new_q[$];
  logic [31:0]   tx_q[$];
  logic [31:0]   rx_q[$];
  logic [AW-1:0] pulse_log[$];
  int            pulse_cnt = 0;
  bit            quiet = 0, loc_pin = 0, oe_may = 0, oe_must = 0, oe_arm = 0;
  logic [31:0]   prev_loc_rdata = '0;
  logic [AW-1:0] prev_loc_addr = '0;
  logic [AW-1:0] cmp_a;
  logic [31:0]   cmp_old, cmp_new;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_regs[i] = '0;
    model_err = 1'b0;
    exp_q.delete();
    exp_old_q.delete();
    exp_new_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic mosi, output logic miso);
    spi_bus.spi_sdi = mosi;
    wait_clk(HALF);
    spi_bus.spi_clk = 1'b1;
    miso = spi_bus.spi_sdo;
    if (oe_arm) begin
      oe_may = 1'b1;
      oe_arm = 1'b0;
    end
    wait_clk(HALF);
    spi_bus.spi_clk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b, input bit arm_last);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0 && arm_last) oe_arm = 1'b1;
      spi_bit(b[i], m);
    end
  endtask

  task automatic spi_word(input logic [31:0] w, input bit is_wr, input logic [AW-1:0] a,
                          output logic [31:0] r);
    logic m;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      if (i == 0 && is_wr) begin
        exp_q.push_back(a);
        exp_old_q.push_back(model_regs[a]);
        exp_new_q.push_back(w);
        model_regs[a] = w;
      end
      spi_bit(w[i], m);
      r = {r[30:0], m};
    end
  endtask

  task automatic do_frame(input logic [7:0] cmd, input logic [7:0] addr,
                          input int nwords, input int tail_bits);
    bit            valid, is_rd;
    logic [AW-1:0] a;
    logic [31:0]   w, r;
    logic          m;
    valid = (cmd == CMD_WRITE) || (cmd == CMD_READ);
    is_rd = (cmd == CMD_READ);
    a     = addr[AW-1:0];
    quiet = 1'b0;
    rx_q.delete();
    spi_bus.spi_csn = 1'b0;
    wait_clk(HALF);
    spi_byte(cmd, 1'b0);
    if (!valid) model_err = 1'b1;
    spi_byte(addr, valid && is_rd);
    if (valid && is_rd) oe_must = 1'b1;
    for (int n = 0; n < nwords; n++) begin
      w = (tx_q.size() > 0) ? tx_q.pop_front() : $urandom;
      spi_word(w, valid && !is_rd, a, r);
      if (valid && is_rd) begin
        check32("read_word", r, model_regs[a]);
        rx_q.push_back(r);
      end
      a = a + 1'b1;
    end
    for (int t = 0; t < tail_bits; t++) spi_bit(1'($urandom_range(0, 1)), m);
    wait_clk(HALF);
    oe_must = 1'b0;
    spi_bus.spi_csn = 1'b1;
    wait_clk(10);
    oe_may = 1'b0;
    check32("err_cmd", 32'(err_cmd), 32'(model_err));
    check32("pending_writes", 32'(exp_q.size()), 32'd0);
    quiet = 1'b1;
    wait_clk(20);
  endtask

  task automatic read_loc(input logic [AW-1:0] a, input logic [31:0] e, input string name);
    bit q;
    q        = quiet;
    quiet    = 1'b0;
    loc_pin  = 1'b1;
    loc_addr = a;
    wait_clk(1);
    check32(name, loc_rdata, e);
    loc_pin = 1'b0;
    quiet   = q;
  endtask

  // Random local-read address while the bus is idle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (quiet && !loc_pin) loc_addr = AW'($urandom_range(0, DEPTH - 1));
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_pulse) begin
        pulse_cnt++;
        pulse_log.push_back(wr_addr);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_pulse: unexpected pulse wr_addr=%0d expected none", wr_addr);
        end else begin
          cmp_a   = exp_q.pop_front();
          cmp_old = exp_old_q.pop_front();
          cmp_new = exp_new_q.pop_front();
          check32("wr_addr", 32'(wr_addr), 32'(cmp_a));
          if (loc_addr == wr_addr && prev_loc_addr == loc_addr) begin
            check32("loc_rdata_write_cycle", prev_loc_rdata, cmp_old);
            check32("loc_rdata_after_write", loc_rdata, cmp_new);
          end
        end
      end
      checks++;
      if ((spi_bus.spi_sdo_oe && !oe_may) || (oe_must && !spi_bus.spi_sdo_oe)) begin
        errors++;
        $display("FAIL sdo_oe: got %0b expected %0b", spi_bus.spi_sdo_oe, oe_must);
      end
      if (quiet) check32("loc_rdata", loc_rdata, model_regs[loc_addr]);
    end
    prev_loc_rdata = loc_rdata;
    prev_loc_addr  = loc_addr;
  end

  // ---------------- main sequence ----------------
  initial begin
    int            p0;
    logic [7:0]    cmd;
    logic [31:0]   w;
    logic          m;
    spi_bus.spi_clk = 1'b0;
    spi_bus.spi_csn = 1'b1;
    spi_bus.spi_sdi = 1'b0;
    model_clear();

    wait_clk(5);
    check32("rst_sdo", 32'(spi_bus.spi_sdo), 32'd0);
    check32("rst_sdo_oe", 32'(spi_bus.spi_sdo_oe), 32'd0);
    check32("rst_wr_pulse", 32'(wr_pulse), 32'd0);
    check32("rst_wr_addr", 32'(wr_addr), 32'd0);
    check32("rst_err_cmd", 32'(err_cmd), 32'd0);
    check32("rst_state", 32'(dbg_state), 32'(IDLE));
    check32("rst_loc_rdata", loc_rdata, 32'd0);
    reset = 1'b0;
    wait_clk(10);
    quiet = 1'b1;
    wait_clk(10);

    // Single write, local address held on the written register.
    quiet    = 1'b0;
    loc_pin  = 1'b1;
    loc_addr = 4'd5;
    p0       = pulse_cnt;
    tx_q.push_back(32'hDEADBEEF);
    do_frame(CMD_WRITE, 8'h05, 1, 0);
    loc_pin = 1'b0;
    read_loc(4'd5, 32'hDEADBEEF, "write_reg5");
    check32("write_pulse_count", 32'(pulse_cnt - p0), 32'd1);
    check32("write_pulse_addr", 32'(pulse_log[pulse_log.size()-1]), 32'd5);
    check32("write_err_cmd", 32'(err_cmd), 32'd0);

    // Preload two words then read them back in one burst.
    tx_q.push_back(32'h12345678);
    tx_q.push_back(32'hA5A5A5A5);
    do_frame(CMD_WRITE, 8'h03, 2, 0);
    do_frame(CMD_READ, 8'h03, 2, 0);
    check32("read_word0", rx_q[0], 32'h12345678);
    check32("read_word1", rx_q[1], 32'hA5A5A5A5);

    // Burst wraps from the last register to register 0.
    pulse_log.delete();
    tx_q.push_back(32'h1);
    tx_q.push_back(32'h2);
    do_frame(CMD_WRITE, 8'h0F, 2, 0);
    read_loc(4'd15, 32'h1, "wrap_reg15");
    read_loc(4'd0, 32'h2, "wrap_reg0");
    check32("wrap_pulses", 32'(pulse_log.size()), 32'd2);
    if (pulse_log.size() == 2) begin
      check32("wrap_addr0", 32'(pulse_log[0]), 32'd15);
      check32("wrap_addr1", 32'(pulse_log[1]), 32'd0);
    end

    // Unknown command: sticky error, no writes, then a valid write still works.
    p0 = pulse_cnt;
    do_frame(8'h9F, 8'h01, 1, 0);
    check32("badcmd_err", 32'(err_cmd), 32'd1);
    check32("badcmd_pulses", 32'(pulse_cnt - p0), 32'd0);
    tx_q.push_back(32'h0BADF00D);
    do_frame(CMD_WRITE, 8'h01, 1, 0);
    read_loc(4'd1, 32'h0BADF00D, "after_badcmd_reg1");

    // Partial word is discarded; the next full frame decodes normally.
    p0 = pulse_cnt;
    do_frame(CMD_WRITE, 8'h07, 0, 20);
    read_loc(4'd7, 32'h0, "partial_reg7");
    check32("partial_pulses", 32'(pulse_cnt - p0), 32'd0);
    tx_q.push_back(32'hCAFEF00D);
    do_frame(CMD_WRITE, 8'h07, 1, 0);
    read_loc(4'd7, 32'hCAFEF00D, "full_reg7");

    // Randomised frames; upper address bits are random and must be ignored.
    for (int f = 0; f < 12; f++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5)      cmd = CMD_WRITE;
      else if (r < 9) cmd = CMD_READ;
      else            cmd = 8'($urandom_range(4, 255));
      do_frame(cmd, 8'($urandom), $urandom_range(1, 3),
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 31) : 0);
    end

    // Reset in the middle of a read data phase.
    quiet = 1'b0;
    tx_q.push_back(32'hFFFF0000);
    do_frame(CMD_WRITE, 8'h02, 1, 0);
    quiet = 1'b0;
    spi_bus.spi_csn = 1'b0;
    wait_clk(HALF);
    spi_byte(CMD_READ, 1'b0);
    spi_byte(8'h02, 1'b1);
    oe_must = 1'b1;
    for (int b = 0; b < 10; b++) spi_bit(1'b0, m);
    reset   = 1'b1;
    oe_must = 1'b0;
    oe_may  = 1'b0;
    wait_clk(1);
    check32("midrst_sdo_oe", 32'(spi_bus.spi_sdo_oe), 32'd0);
    check32("midrst_sdo", 32'(spi_bus.spi_sdo), 32'd0);
    model_clear();
    reset = 1'b0;
    for (int b = 0; b < 8; b++) spi_bit(1'b1, m);
    wait_clk(HALF);
    spi_bus.spi_csn = 1'b1;
    wait_clk(10);
    for (int i = 0; i < DEPTH; i++) read_loc(AW'(i), 32'h0, "midrst_reg_zero");
    check32("midrst_err_cmd", 32'(err_cmd), 32'd0);
    quiet = 1'b1;
    wait_clk(10);
    w = $urandom;
    tx_q.push_back(w);
    do_frame(CMD_WRITE, 8'h0A, 1, 0);
    do_frame(CMD_READ, 8'h0A, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached before end of sequence");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
